// File: rtl/t_mod_counter_pkg.sv
// Shared constants and types for the modulo-N toggle counter.
package t_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/t_mod_counter_ff_stage.sv
// Single toggle flip-flop with registered complement output.
module t_ff_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q,
  output logic qbar
);

  // Toggle on t; qbar is registered from the same next value so it never lags q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= 1'b0;
      qbar <= 1'b1;
    end else begin
      q    <= q ^ t;
      qbar <= ~(q ^ t);
    end
  end

endmodule

// File: rtl/t_mod_counter.sv
// Programmable modulo-N up/down counter built from per-bit toggle stages,
// with a one-cycle terminal-count pulse and a wrap-driven divide-by-two output.
module t_mod_counter
  import t_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             div_out
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             wrap;
  logic             div_q;
  logic             div_qbar;

  // Next count and wrap detection: load > enabled step > hold.
  always_comb begin
    nxt  = q;
    wrap = 1'b0;
    if (load) begin
      nxt = (load_val > mod_max) ? mod_max : load_val;
    end else if (en) begin
      if (up == DIR_UP) begin
        if (q >= mod_max) begin
          nxt  = '0;
          wrap = 1'b1;
        end else begin
          nxt = q + ONE;
        end
      end else begin
        if ((q == '0) || (q > mod_max)) begin
          nxt  = mod_max;
          wrap = 1'b1;
        end else begin
          nxt = q - ONE;
        end
      end
    end
  end

  // Toggle inputs: a bit flips exactly where the current and next count differ.
  always_comb begin
    t = q ^ nxt;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_stage u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .t    (t[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  t_ff_stage u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .t    (wrap),
    .q    (div_q),
    .qbar (div_qbar)
  );

  // The divider stage's rails are always complementary; combining them
  // reduces to div_q while keeping both stage outputs referenced.
  assign div_out = div_q & ~div_qbar;

  // Terminal-count pulse: registered wrap, cleared on load and hold cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc <= 1'b0;
    end else begin
      tc <= wrap;
    end
  end

endmodule

// File: tb/tb_t_mod_counter.sv
// Self-checking bench for t_mod_counter (WIDTH=4): directed vectors with
// literal expectations plus a per-cycle comparison against a behavioural model.
module tb_t_mod_counter;
  import t_counter_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   en = 1'b0;
  logic   up = 1'b1;
  logic   load = 1'b0;
  count_t load_val = '0;
  count_t mod_max = 4'd9;
  count_t q;
  count_t qbar;
  logic   tc;
  logic   div_out;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  // Behavioural model state
  int m_q = 0;
  int m_tc = 0;
  int m_div = 0;

  t_mod_counter #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .mod_max (mod_max),
    .q       (q),
    .qbar    (qbar),
    .tc      (tc),
    .div_out (div_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model of the counting rules in plain integer arithmetic.
  always @(posedge clk or negedge rst_n) begin
    int mm;
    int w;
    if (!rst_n) begin
      m_q = 0; m_tc = 0; m_div = 0;
    end else begin
      mm = int'(mod_max);
      w = 0;
      if (load) begin
        m_q = (int'(load_val) < mm) ? int'(load_val) : mm;
      end else if (en) begin
        if (up) begin
          if (m_q >= mm) begin m_q = 0; w = 1; end
          else m_q = m_q + 1;
        end else begin
          if (m_q == 0 || m_q > mm) begin m_q = mm; w = 1; end
          else m_q = m_q - 1;
        end
      end
      m_tc = w;
      m_div = m_div ^ w;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_q", int'(q), m_q);
      check("model_qbar", int'(qbar), 15 - m_q);
      check("model_tc", int'(tc), m_tc);
      check("model_div", int'(div_out), m_div);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    check("rst_q", int'(q), 0);
    check("rst_qbar", int'(qbar), 15);
    check("rst_tc", int'(tc), 0);
    check("rst_div", int'(div_out), 0);
    cmp_on = 1'b1;

    // Up count, mod 9
    rst_n = 1'b1; en = 1'b1; up = DIR_UP; mod_max = 4'd9;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      check("up_q", int'(q), i % 10);
      check("up_qbar", int'(qbar), 15 - (i % 10));
      check("up_tc", int'(tc), (i == 10) ? 1 : 0);
      check("up_div", int'(div_out), (i >= 10) ? 1 : 0);
    end

    // Down wrap from a loaded 2
    load = 1'b1; load_val = 4'd2; en = 1'b0;
    cyc();
    check("ld2_q", int'(q), 2);
    load = 1'b0; en = 1'b1; up = DIR_DOWN;
    cyc(); check("dn_q1", int'(q), 1); check("dn_tc1", int'(tc), 0);
    cyc(); check("dn_q0", int'(q), 0); check("dn_tc0", int'(tc), 0);
    cyc(); check("dn_q9", int'(q), 9); check("dn_tc9", int'(tc), 1);
    check("dn_div9", int'(div_out), 0);
    cyc(); check("dn_q8", int'(q), 8); check("dn_tc8", int'(tc), 0);

    // Load priority over en, clamped to mod_max
    load = 1'b1; en = 1'b1; up = DIR_UP; load_val = 4'd13;
    cyc(); check("clamp_q", int'(q), 9); check("clamp_tc", int'(tc), 0);
    load = 1'b0;
    cyc(); check("clamp_wrap_q", int'(q), 0); check("clamp_wrap_tc", int'(tc), 1);
    check("clamp_wrap_div", int'(div_out), 1);

    // Modulus shrink below current count, up step
    load = 1'b1; load_val = 4'd7; en = 1'b0;
    cyc(); check("shr_ld_q", int'(q), 7);
    load = 1'b0; mod_max = 4'd4; en = 1'b1; up = DIR_UP;
    cyc(); check("shr_up_q", int'(q), 0); check("shr_up_tc", int'(tc), 1);
    check("shr_up_div", int'(div_out), 0);

    // Modulus shrink below current count, down step
    mod_max = 4'd9; load = 1'b1; load_val = 4'd7; en = 1'b0;
    cyc(); check("shr_ld2_q", int'(q), 7);
    load = 1'b0; mod_max = 4'd4; en = 1'b1; up = DIR_DOWN;
    cyc(); check("shr_dn_q", int'(q), 4); check("shr_dn_tc", int'(tc), 1);
    check("shr_dn_div", int'(div_out), 1);

    // mod_max = 0: every enabled cycle wraps
    load = 1'b1; load_val = 4'd0; en = 1'b0;
    cyc(); check("m0_ld_q", int'(q), 0); check("m0_ld_tc", int'(tc), 0);
    load = 1'b0; mod_max = 4'd0; en = 1'b1; up = DIR_UP;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("m0_q", int'(q), 0);
      check("m0_tc", int'(tc), 1);
      check("m0_div", int'(div_out), (i % 2 == 0) ? 0 : 1);
    end

    // Full-range binary rollover
    mod_max = 4'd15; load = 1'b1; load_val = 4'd14;
    cyc(); check("full_ld_q", int'(q), 14);
    load = 1'b0; up = DIR_UP;
    cyc(); check("full_q15", int'(q), 15); check("full_tc15", int'(tc), 0);
    cyc(); check("full_q0", int'(q), 0); check("full_tc0", int'(tc), 1);
    up = DIR_DOWN;
    cyc(); check("full_dn_q", int'(q), 15); check("full_dn_tc", int'(tc), 1);

    // Hold when idle
    en = 1'b0;
    cyc(); check("hold_q", int'(q), 15); check("hold_tc", int'(tc), 0);

    // Direction changing every cycle, checked by the model
    mod_max = 4'd5; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      up = (i % 3 == 0) ? DIR_DOWN : DIR_UP;
      en = (i % 5 != 4);
      cyc();
    end

    // Async reset mid-count
    mod_max = 4'd9; up = DIR_UP; load = 1'b1; load_val = 4'd5;
    cyc(); load = 1'b0; en = 1'b1;
    cyc(); check("ar_pre_q", int'(q), 6);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_q", int'(q), 0);
    check("ar_qbar", int'(qbar), 15);
    check("ar_tc", int'(tc), 0);
    check("ar_div", int'(div_out), 0);
    cyc();
    rst_n = 1'b1; en = 1'b1; up = DIR_UP;
    cyc(); check("ar_rel_q", int'(q), 1);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
